// File: rtl/axi_ad7124_trigger.sv
// RTC-timed measurement scheduler: arms at an absolute RTC deadline, then
// issues measure_start pulses every period for a fixed or unlimited count,
// skipping (and counting) deadlines that expire while a measurement runs.
module axi_ad7124_trigger #(
  parameter int unsigned OVR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rtc_sec,
  input  logic [31:0]      rtc_nsec,
  input  logic             ctrl_enable,
  input  logic             ctrl_abort,
  input  logic [31:0]      ctrl_start_sec,
  input  logic [31:0]      ctrl_start_nsec,
  input  logic [31:0]      ctrl_period_nsec,
  input  logic [31:0]      ctrl_count,
  output logic             measure_start,
  input  logic             measure_ready,
  input  logic             measure_done,
  output logic [2:0]       stat_state,
  output logic [31:0]      stat_trig_count,
  output logic [OVR_W-1:0] stat_overrun,
  output logic             stat_cfg_err,
  output logic             irq
);

  localparam logic [31:0] NsPerSec = 32'd1_000_000_000;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArm  = 3'd1,
    StFire = 3'd2,
    StBusy = 3'd3,
    StWait = 3'd4,
    StDone = 3'd5
  } state_e;

  state_e           state_q;
  logic             en_q;
  logic [31:0]      d_sec_q, d_nsec_q;
  logic [31:0]      per_q, cnt_q;
  logic [31:0]      trig_q;
  logic [OVR_W-1:0] ovr_q;
  logic             cfg_err_q, start_q, irq_q;

  logic             reached;
  logic [31:0]      sum_nsec, adv_nsec, adv_sec;
  logic             cfg_bad;

  // Deadline comparison and one-period advance of the deadline.
  always_comb begin
    reached  = (rtc_sec > d_sec_q) || ((rtc_sec == d_sec_q) && (rtc_nsec >= d_nsec_q));
    sum_nsec = d_nsec_q + per_q;
    adv_nsec = sum_nsec;
    adv_sec  = d_sec_q;
    if (sum_nsec >= NsPerSec) begin
      adv_nsec = sum_nsec - NsPerSec;
      adv_sec  = d_sec_q + 32'd1;
    end
    cfg_bad = (ctrl_period_nsec == 32'd0) || (ctrl_period_nsec >= NsPerSec) ||
              (ctrl_start_nsec >= NsPerSec);
  end

  // Scheduler FSM with registered start/irq pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      d_sec_q   <= 32'd0;
      d_nsec_q  <= 32'd0;
      per_q     <= 32'd0;
      cnt_q     <= 32'd0;
      trig_q    <= 32'd0;
      ovr_q     <= '0;
      cfg_err_q <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q    <= ctrl_enable;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
      // Abort or disable wins over every other transition outside idle.
      if ((state_q != StIdle) && (ctrl_abort || !ctrl_enable)) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ctrl_enable && !en_q) begin
              d_sec_q  <= ctrl_start_sec;
              d_nsec_q <= ctrl_start_nsec;
              per_q    <= ctrl_period_nsec;
              cnt_q    <= ctrl_count;
              trig_q   <= 32'd0;
              ovr_q    <= '0;
              if (cfg_bad) begin
                cfg_err_q <= 1'b1;
              end else begin
                cfg_err_q <= 1'b0;
                state_q   <= StArm;
              end
            end
          end
          StArm, StWait: begin
            if (reached) state_q <= StFire;
          end
          StFire: begin
            if (measure_ready) begin
              start_q  <= 1'b1;
              trig_q   <= trig_q + 32'd1;
              d_sec_q  <= adv_sec;
              d_nsec_q <= adv_nsec;
              state_q  <= StBusy;
            end
          end
          StBusy: begin
            // Skip one expired deadline per cycle until caught up.
            if (reached) begin
              d_sec_q  <= adv_sec;
              d_nsec_q <= adv_nsec;
              if (ovr_q != '1) ovr_q <= ovr_q + 1'b1;
            end
            if (measure_done) begin
              if ((cnt_q != 32'd0) && (trig_q == cnt_q)) state_q <= StDone;
              else                                         state_q <= StWait;
            end
          end
          StDone: begin
            irq_q   <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign measure_start   = start_q;
  assign irq             = irq_q;
  assign stat_state      = state_q;
  assign stat_trig_count = trig_q;
  assign stat_overrun    = ovr_q;
  assign stat_cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_axi_ad7124_trigger.sv
// Directed bench for axi_ad7124_trigger: a scoreboard of expected start
// deadlines is filled at arm time and checked against the bench's own RTC
// history whenever measure_start pulses.
module tb_axi_ad7124_trigger;

  localparam int unsigned OVR_W = 16;

  logic             clk, rst;
  logic [31:0]      rtc_sec, rtc_nsec;
  logic             ctrl_enable, ctrl_abort;
  logic [31:0]      ctrl_start_sec, ctrl_start_nsec, ctrl_period_nsec, ctrl_count;
  logic             measure_start, measure_ready, measure_done;
  logic [2:0]       stat_state;
  logic [31:0]      stat_trig_count;
  logic [OVR_W-1:0] stat_overrun;
  logic             stat_cfg_err, irq;

  axi_ad7124_trigger #(.OVR_W(OVR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .rtc_sec          (rtc_sec),
    .rtc_nsec         (rtc_nsec),
    .ctrl_enable      (ctrl_enable),
    .ctrl_abort       (ctrl_abort),
    .ctrl_start_sec   (ctrl_start_sec),
    .ctrl_start_nsec  (ctrl_start_nsec),
    .ctrl_period_nsec (ctrl_period_nsec),
    .ctrl_count       (ctrl_count),
    .measure_start    (measure_start),
    .measure_ready    (measure_ready),
    .measure_done     (measure_done),
    .stat_state       (stat_state),
    .stat_trig_count  (stat_trig_count),
    .stat_overrun     (stat_overrun),
    .stat_cfg_err     (stat_cfg_err),
    .irq              (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] d;
    bit          exact;
  } sb_t;

  sb_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  int          start_cnt = 0;
  int          irq_cnt = 0;
  int          done_cnt = 0;
  int          done_delay = 20;
  bit          auto_done = 1'b1;
  logic [63:0] h0 = 64'd0, h1 = 64'd0, h2 = 64'd0;

  function automatic logic [63:0] tot(input logic [31:0] s, input logic [31:0] n);
    return ({32'd0, s} * 64'd1_000_000_000) + {32'd0, n};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input bit exact);
    sb_t e;
    e.d     = d;
    e.exact = exact;
    sb.push_back(e);
  endtask

  // One clock: record RTC history, sample after the edge, run the done
  // responder and scoreboard, then advance the RTC by 10 ns.
  task automatic step();
    sb_t e;
    h2 = h1;
    h1 = h0;
    h0 = tot(rtc_sec, rtc_nsec);
    @(posedge clk);
    #1;
    measure_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) measure_done = 1'b1;
    end
    if (measure_start === 1'b1) begin
      start_cnt++;
      check("start_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("start_after_deadline", 64'(h1 >= e.d), 64'd1);
        if (e.exact) check("start_latency_2", 64'(h2 < e.d), 64'd1);
      end
      if (auto_done) done_cnt = done_delay;
    end
    if (irq === 1'b1) irq_cnt++;
    rtc_nsec = rtc_nsec + 32'd10;
    if (rtc_nsec >= 32'd1_000_000_000) begin
      rtc_nsec = rtc_nsec - 32'd1_000_000_000;
      rtc_sec  = rtc_sec + 32'd1;
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && start_cnt < n; i++) step();
    check(tag, 64'(start_cnt >= n), 64'd1);
  endtask

  task automatic wait_irq(input int budget, input string tag);
    for (int i = 0; i < budget && irq_cnt < 1; i++) step();
    check(tag, 64'(irq_cnt >= 1), 64'd1);
  endtask

  task automatic setup(input logic [31:0] rs, input logic [31:0] ss, input logic [31:0] sn,
                       input logic [31:0] per, input logic [31:0] cnt);
    ctrl_enable = 1'b0;
    step();
    step();
    sb.delete();
    start_cnt  = 0;
    irq_cnt    = 0;
    done_cnt   = 0;
    done_delay = 20;
    auto_done  = 1'b1;
    rtc_sec          = rs;
    rtc_nsec         = 32'd0;
    ctrl_start_sec   = ss;
    ctrl_start_nsec  = sn;
    ctrl_period_nsec = per;
    ctrl_count       = cnt;
  endtask

  logic [63:0] d0;

  initial begin
    rst = 1'b1;
    rtc_sec = 32'd0; rtc_nsec = 32'd0;
    ctrl_enable = 1'b0; ctrl_abort = 1'b0;
    ctrl_start_sec = 32'd0; ctrl_start_nsec = 32'd0;
    ctrl_period_nsec = 32'd0; ctrl_count = 32'd0;
    measure_ready = 1'b1; measure_done = 1'b0;
    #12;
    check("rst_state", 64'(stat_state), 64'd0);
    check("rst_start", 64'(measure_start), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_trig", 64'(stat_trig_count), 64'd0);
    check("rst_ovr", 64'(stat_overrun), 64'd0);
    check("rst_cfg_err", 64'(stat_cfg_err), 64'd0);
    rst = 1'b0;
    step();

    // 1: count=3, period 500, nsec carry on the third deadline.
    setup(32'd10, 32'd10, 32'd999_999_000, 32'd500, 32'd3);
    rtc_nsec = 32'd999_998_000;
    d0 = tot(32'd10, 32'd999_999_000);
    push(d0, 1'b1);
    push(d0 + 64'd500, 1'b1);
    push(tot(32'd11, 32'd0), 1'b1);
    ctrl_enable = 1'b1;
    step();
    check("t1_arm_state", 64'(stat_state), 64'd1);
    check("t1_arm_cfg_err", 64'(stat_cfg_err), 64'd0);
    wait_starts(1, 300, "t1_start1_timeout");
    check("t1_busy_state", 64'(stat_state), 64'd3);
    check("t1_trig1", 64'(stat_trig_count), 64'd1);
    wait_starts(3, 300, "t1_start3_timeout");
    wait_irq(100, "t1_irq_timeout");
    for (int i = 0; i < 5; i++) step();
    check("t1_irq_once", 64'(irq_cnt), 64'd1);
    check("t1_trig", 64'(stat_trig_count), 64'd3);
    check("t1_state_idle", 64'(stat_state), 64'd0);
    check("t1_starts", 64'(start_cnt), 64'd3);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: done delayed 3500 ns with period 1000 -> three skipped deadlines.
    setup(32'd20, 32'd20, 32'd1000, 32'd1000, 32'd2);
    d0 = tot(32'd20, 32'd1000);
    push(d0, 1'b1);
    push(d0 + 64'd4000, 1'b1);
    done_delay = 350;
    ctrl_enable = 1'b1;
    step();
    wait_starts(1, 200, "t2_start1_timeout");
    done_delay = 20;
    wait_starts(2, 800, "t2_start2_timeout");
    wait_irq(100, "t2_irq_timeout");
    check("t2_overrun", 64'(stat_overrun), 64'd3);
    check("t2_trig", 64'(stat_trig_count), 64'd2);
    check("t2_starts", 64'(start_cnt), 64'd2);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: ready held low 50 cycles past the deadline.
    setup(32'd30, 32'd30, 32'd500, 32'd1000, 32'd1);
    measure_ready = 1'b0;
    d0 = tot(32'd30, 32'd500);
    push(d0, 1'b0);
    ctrl_enable = 1'b1;
    step();
    for (int i = 0; i < 200 && tot(rtc_sec, rtc_nsec) < d0; i++) step();
    for (int i = 0; i < 50; i++) step();
    check("t3_fire_state", 64'(stat_state), 64'd2);
    check("t3_no_start", 64'(start_cnt), 64'd0);
    measure_ready = 1'b1;
    step();
    check("t3_start_after_ready", 64'(measure_start), 64'd1);
    check("t3_trig", 64'(stat_trig_count), 64'd1);
    wait_irq(100, "t3_irq_timeout");
    check("t3_starts", 64'(start_cnt), 64'd1);
    check("t3_overrun", 64'(stat_overrun), 64'd0);

    // 4: rejected configurations, then a valid re-arm.
    setup(32'd40, 32'd41, 32'd0, 32'd0, 32'd1);
    ctrl_enable = 1'b1;
    step();
    check("t4_p0_cfg_err", 64'(stat_cfg_err), 64'd1);
    check("t4_p0_state", 64'(stat_state), 64'd0);
    ctrl_enable = 1'b0;
    step();
    ctrl_period_nsec = 32'd1_000_000_000;
    ctrl_enable = 1'b1;
    step();
    check("t4_p1e9_cfg_err", 64'(stat_cfg_err), 64'd1);
    check("t4_p1e9_state", 64'(stat_state), 64'd0);
    ctrl_enable = 1'b0;
    step();
    ctrl_period_nsec = 32'd100;
    ctrl_enable = 1'b1;
    step();
    check("t4_ok_cfg_err", 64'(stat_cfg_err), 64'd0);
    check("t4_ok_state", 64'(stat_state), 64'd1);
    check("t4_no_start", 64'(start_cnt), 64'd0);

    // 5: continuous mode, abort coincident with measure_done.
    setup(32'd50, 32'd50, 32'd100, 32'd500, 32'd0);
    d0 = tot(32'd50, 32'd100);
    for (int k = 0; k < 5; k++) push(d0 + 64'(k * 500), 1'b1);
    ctrl_enable = 1'b1;
    step();
    wait_starts(4, 1000, "t5_start4_timeout");
    auto_done = 1'b0;
    wait_starts(5, 200, "t5_start5_timeout");
    check("t5_busy_state", 64'(stat_state), 64'd3);
    measure_done = 1'b1;
    ctrl_abort = 1'b1;
    step();
    check("t5_abort_state", 64'(stat_state), 64'd0);
    check("t5_abort_irq", 64'(irq), 64'd0);
    ctrl_abort = 1'b0;
    ctrl_enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t5_trig_hold", 64'(stat_trig_count), 64'd5);
    check("t5_no_irq", 64'(irq_cnt), 64'd0);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // 6: asynchronous reset in the middle of BUSY.
    setup(32'd60, 32'd60, 32'd100, 32'd1000, 32'd2);
    push(tot(32'd60, 32'd100), 1'b1);
    ctrl_enable = 1'b1;
    step();
    wait_starts(1, 200, "t6_start_timeout");
    auto_done = 1'b0;
    done_cnt  = 0;
    step();
    step();
    check("t6_pre_busy", 64'(stat_state), 64'd3);
    #3;
    rst = 1'b1;
    ctrl_enable = 1'b0;
    #1;
    check("t6_rst_state", 64'(stat_state), 64'd0);
    check("t6_rst_trig", 64'(stat_trig_count), 64'd0);
    check("t6_rst_start", 64'(measure_start), 64'd0);
    check("t6_rst_irq", 64'(irq), 64'd0);
    #2;
    rst = 1'b0;
    measure_done = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    check("t6_done_ignored", 64'(stat_state), 64'd0);
    check("t6_starts", 64'(start_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
